// File: rtl/icb_sram_slave_if.sv
// ICB command/response bundle between an initiator and a memory-style responder.
// Pure wiring: no latency, no flow-control logic of its own.
interface icb_sram_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [DW-1:0] icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic [DW-1:0] icb_rsp_rdata;
  logic          icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/icb_sram_slave.sv
// ICB responder backed by a byte-maskable register-array memory, in-order responses.
// Latency: response valid the cycle after command accept; one command per cycle.
// Backpressure: up to 2 responses outstanding, then cmd_ready drops until one is consumed.
module icb_sram_slave #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              MEM_DEPTH = 256,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  icb_sram_slave_if.slave   icb
);
  localparam int            IDX_W = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] SPAN  = AW'(MEM_DEPTH * 4);

  logic [DW-1:0]    mem [MEM_DEPTH];

  logic [AW-1:0]    off;
  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             rsp_fire;
  logic [DW-1:0]    rsp_dat;

  // Two-entry response queue; the accept edge is the capture point of the in-flight stage.
  logic [DW-1:0]    fifo_dat [2];
  logic             fifo_err [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       outstanding;
  logic             ready_q;

  assign off    = icb.icb_cmd_addr - BASE_ADDR;
  assign legal  = (off[1:0] == 2'b00) && (off < SPAN);
  assign idx    = off[IDX_W+1:2];

  assign icb.icb_cmd_ready = ready_q && (outstanding != 2'd2);
  assign accept            = icb.icb_cmd_valid && icb.icb_cmd_ready && rst_n;
  assign icb.icb_rsp_valid = (outstanding != 2'd0);
  assign rsp_fire          = icb.icb_rsp_valid && icb.icb_rsp_ready;

  assign rsp_dat = (legal && icb.icb_cmd_read) ? mem[idx] : '0;

  assign icb.icb_rsp_rdata = icb.icb_rsp_valid ? fifo_dat[rd_ptr] : '0;
  assign icb.icb_rsp_err   = icb.icb_rsp_valid ? fifo_err[rd_ptr] : 1'b0;

  // Memory is never reset so accepted writes survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && legal && !icb.icb_cmd_read) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (icb.icb_cmd_wmask[b]) begin
          mem[idx][8*b +: 8] <= icb.icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_dat[wr_ptr] <= rsp_dat;
      fifo_err[wr_ptr] <= !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      outstanding <= 2'd0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        wr_ptr <= !wr_ptr;
      end
      if (rsp_fire) begin
        rd_ptr <= !rd_ptr;
      end
      case ({accept, rsp_fire})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_icb_sram_slave.sv
// Directed vector bench for icb_sram_slave: table of single transactions plus
// hand-written backpressure, back-to-back and mid-operation reset sequences.
module tb_icb_sram_slave;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  icb_sram_slave_if #(.AW(32), .DW(32)) bus ();

  icb_sram_slave #(
    .AW(32), .DW(32), .MEM_DEPTH(256), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = a;
    bus.icb_cmd_wdata = wd;
    bus.icb_cmd_wmask = m;
  endtask

  // Called at a negedge with rsp_ready = 1; returns at the negedge after accept.
  task automatic run_cmd(input string nm, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         input logic [31:0] er, input logic ee);
    int w;
    w = 0;
    drive(rd, a, wd, m);
    while (!bus.icb_cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!bus.icb_cmd_ready) begin
      total++;
      bad++;
      $display("FAIL %s: cmd_ready timeout, got 0, expected 1", nm);
      bus.icb_cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    total++;
    if (!(bus.icb_rsp_valid === 1'b1 && bus.icb_rsp_rdata === er && bus.icb_rsp_err === ee)) begin
      bad++;
      $display("FAIL %s: got valid=%b rdata=%h err=%b, expected valid=1 rdata=%h err=%b",
               nm, bus.icb_rsp_valid, bus.icb_rsp_rdata, bus.icb_rsp_err, er, ee);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bp_addr [3];
    logic        acc;
    int          k;

    total = 0;
    bad   = 0;
    vt[0]  = '{1'b0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 32'h24,  32'h12345678, 4'hF, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h24,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vt[4]  = '{1'b1, 32'h24,  32'h0,        4'hF, 32'h12BB56DD, 1'b0};
    vt[5]  = '{1'b1, 32'h402, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[6]  = '{1'b1, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[8]  = '{1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[10] = '{1'b0, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vt[11] = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1};
    vt[12] = '{1'b1, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vt[13] = '{1'b0, 32'h3FC, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h3FC, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vt[15] = '{1'b1, 32'h3FC, 32'h0,        4'h0, 32'h11223344, 1'b0};
    vt[16] = '{1'b1, 32'h3FE, 32'h0,        4'h0, 32'h0,        1'b1};

    rst_n             = 1'b0;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.icb_cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.icb_rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.icb_rsp_rdata, 32'd0);
    chk("reset_rsp_err",   32'(bus.icb_rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", 32'(bus.icb_cmd_ready), 32'd1);

    bus.icb_rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run_cmd($sformatf("vec%0d", i), vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].wmask,
              vt[i].exp_rdata, vt[i].exp_err);
    end
    @(negedge clk);
    chk("drained_rsp_valid", 32'(bus.icb_rsp_valid), 32'd0);

    // Response backpressure: three reads offered, only two may be taken.
    bp_addr[0] = 32'h10;
    bp_addr[1] = 32'h24;
    bp_addr[2] = 32'h10;
    bus.icb_rsp_ready = 1'b0;
    k = 0;
    drive(1'b1, bp_addr[0], 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      acc = bus.icb_cmd_ready;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
      if (k < 3) drive(1'b1, bp_addr[k], 32'h0, 4'h0);
      chk("bp_rsp_valid", 32'(bus.icb_rsp_valid), 32'd1);
      chk("bp_rdata_stable", bus.icb_rsp_rdata, 32'hDEADBEEF);
    end
    chk("bp_accepted", 32'(k), 32'd2);
    chk("bp_cmd_ready_low", 32'(bus.icb_cmd_ready), 32'd0);
    bus.icb_rsp_ready = 1'b1;
    acc = bus.icb_cmd_ready;
    @(posedge clk);
    if (acc) k++;
    @(negedge clk);
    chk("bp_third_waits", 32'(k), 32'd2);
    chk("bp_second_rsp", bus.icb_rsp_rdata, 32'h12BB56DD);
    chk("bp_cmd_ready_back", 32'(bus.icb_cmd_ready), 32'd1);
    acc = bus.icb_cmd_ready;
    @(posedge clk);
    if (acc) k++;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    chk("bp_third_accepted", 32'(k), 32'd3);
    chk("bp_third_rsp", bus.icb_rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("bp_drained", 32'(bus.icb_rsp_valid), 32'd0);

    // Back-to-back write then read of the same word.
    drive(1'b0, 32'h30, 32'h0000_00FF, 4'hF);
    chk("b2b_wr_ready", 32'(bus.icb_cmd_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h30, 32'h0, 4'h0);
    chk("b2b_rd_ready", 32'(bus.icb_cmd_ready), 32'd1);
    chk("b2b_wr_rsp_valid", 32'(bus.icb_rsp_valid), 32'd1);
    chk("b2b_wr_rsp_rdata", bus.icb_rsp_rdata, 32'h0);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    chk("b2b_rd_rsp_valid", 32'(bus.icb_rsp_valid), 32'd1);
    chk("b2b_rd_rsp_rdata", bus.icb_rsp_rdata, 32'h0000_00FF);
    @(negedge clk);

    // Reset with two responses pending.
    bus.icb_rsp_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 32'h38, 32'h55AA55AA, 4'hF);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    chk("rst_pending_valid", 32'(bus.icb_rsp_valid), 32'd1);
    chk("rst_pending_full", 32'(bus.icb_cmd_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(bus.icb_rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.icb_cmd_ready), 32'd0);
    chk("midrst_rsp_rdata", bus.icb_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_cmd_ready", 32'(bus.icb_cmd_ready), 32'd1);
    chk("after_rst_rsp_valid", 32'(bus.icb_rsp_valid), 32'd0);
    bus.icb_rsp_ready = 1'b1;
    run_cmd("retained_0x24", 1'b1, 32'h24, 32'h0, 4'h0, 32'h12BB56DD, 1'b0);
    run_cmd("retained_0x38", 1'b1, 32'h38, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
